id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute boundary of the five-stage pipeline. Selects each source operand from the register file or the forwarding network. Detects load-use hazards against loads in EX and MEM, and inserts bubbles while holding IF/ID. Registers the resulting ID/EX packet consumed by the execute stage and the forwarding logic.

## Interface
Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle carried to EX (ALU op, operand selects, branch type).
- XLEN, 32, datapath width.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_pc  in  XLEN  PC of the decoding instruction.
- if_id_rs1, if_id_rs2  in  5  source register indices.
- if_id_dest_reg_idx  in  5  destination index (0 = no write).
- if_id_rd_mem, if_id_wr_mem  in  1  instruction is a load / store.
- if_id_ctrl  in  CTRL_W  decoded control bundle.
- rf_rega, rf_regb  in  XLEN  register-file read data for rs1/rs2.
- forward_rs1, forward_rs2  in  1  forwarding unit claims the operand.
- forward_rega_out, forward_regb_out  in  XLEN  forwarded operand values.
- ex_mem_dest_reg_idx  in  5  destination of the instruction in MEM.
- ex_mem_rd_mem  in  1  instruction in MEM is a load.
- mem_stall  in  1  memory stage busy; freeze ID/EX.
- ex_take_branch  in  1  EX redirects fetch; squash the younger instruction.
- id_ex_valid  out  1  ID/EX holds a real instruction.
- id_ex_pc  out  XLEN  registered PC.
- id_ex_rega, id_ex_regb  out  XLEN  registered resolved operands.
- id_ex_dest_reg_idx  out  5  registered destination.
- id_ex_rd_mem, id_ex_wr_mem  out  1  registered load/store flags.
- id_ex_ctrl  out  CTRL_W  registered control bundle.
- if_id_stall  out  1  combinational; hold PC and IF/ID this cycle.
- load_use_stall_cycles  out  32  saturating count of bubble-insert cycles.

## Operation
- Operand select: id_rega = forward_rs1 ? forward_rega_out : rf_rega. Operand B is selected the same way.
- Load-use hazard is asserted when if_id_valid is set and either:
  - id_ex_valid & id_ex_rd_mem & id_ex_dest_reg_idx≠0, and the destination equals rs1 or rs2.
  - ex_mem_rd_mem & ex_mem_dest_reg_idx≠0, and the destination equals rs1 or rs2.
- Per-edge update priority:
  1. reset: all ID/EX outputs 0, id_ex_valid=0, counter=0.
  2. mem_stall: all ID/EX registers hold; counter holds; ex_take_branch is ignored. EX holds ex_take_branch until the stall releases.
  3. ex_take_branch: load a bubble (valid, rd_mem, wr_mem, dest and ctrl all 0; pc/operands 0).
  4. load-use hazard: load a bubble; counter increments, saturating at 0xFFFF_FFFF.
  5. otherwise: capture the IF/ID packet with the selected operands. valid = if_id_valid. If if_id_valid=0, rd_mem, wr_mem and dest are forced to 0.
- if_id_stall = mem_stall | (load-use hazard & !ex_take_branch).
- A bubble never sets rd_mem or dest, so a bubble cannot trigger a hazard or forwarding.

## Timing
- Latency: one cycle from IF/ID to ID/EX.
- A load directly followed by a dependent instruction costs 2 bubble cycles: the first while the load is in EX, the second while it is in MEM. The operand is captured on the third edge.
- A dependent instruction one slot behind a load costs 1 bubble.
- Every output except if_id_stall is registered.
- reset asserted mid-stall clears the outputs and counter on that edge. if_id_stall follows its inputs combinationally and is not held during reset.
- Simultaneous flush and hazard: flush wins; no stall and no count increment.
- Simultaneous mem_stall and hazard: hold, no count increment.

## Structure
- Shared pipeline package:
  - id_ex_packet_t struct: valid, pc, rega, regb, dest, rd_mem, wr_mem, ctrl.
  - ID_EX_NOP constant (all-zero packet).
  - XLEN and CTRL_W defaults.
- Optional sub-module load_use_detect (purely combinational hazard compare). Everything else lives in id_ex_stage.

## Test plan
- Reset: assert reset 2 cycles with random inputs -> all outputs 0, counter 0, id_ex_valid 0.
- Forward select: forward_rs1=1 with forward_rega_out=0xDEAD_BEEF, rf_rega=0x1234 -> id_ex_rega=0xDEAD_BEEF next cycle. With forward_rs1=0 -> 0x1234.
- Load-use:
  - Sequence: lw x5; add x6,x5,x1 -> two bubble cycles (id_ex_valid 0), if_id_stall high for 2 cycles, counter=2. add captured on the third edge.
  - Same dependency with x0 as destination -> no stall.
- Flush vs hazard: ex_take_branch=1 in the same cycle as a hazard -> bubble, if_id_stall=0, counter unchanged.
- mem_stall: hold 3 cycles with new IF/ID values and ex_take_branch=1 -> ID/EX unchanged, if_id_stall=1, no squash.
- Counter saturation: preload near 0xFFFF_FFFF via forced state, 3 hazard cycles -> counter stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared pipeline definitions for the decode-to-execute boundary:
//   - default datapath / control-bundle widths
//   - id_ex_packet_t, the registered ID/EX packet
//   - ID_EX_NOP, the all-zero bubble packet
//   - sat_inc32, saturating increment used by the stall counter
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CTRL_W_DEF = 16;
  localparam int REG_IDX_W  = 5;

  typedef struct packed {
    logic                  valid;
    logic [XLEN_DEF-1:0]   pc;
    logic [XLEN_DEF-1:0]   rega;
    logic [XLEN_DEF-1:0]   regb;
    logic [REG_IDX_W-1:0]  dest;
    logic                  rd_mem;
    logic                  wr_mem;
    logic [CTRL_W_DEF-1:0] ctrl;
  } id_ex_packet_t;

  // A bubble carries no destination and no load flag, so it can never
  // trigger a hazard or be picked up by the forwarding network.
  localparam id_ex_packet_t ID_EX_NOP = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX boundary.
//   master : the surrounding pipeline (IF/ID, register file, forwarding unit,
//            MEM stage, EX redirect); drives inputs, observes ID/EX outputs.
//   slave  : id_ex_stage itself.
// Signals:
//   if_id_*            decoded instruction sitting in IF/ID
//   rf_rega/regb       register-file read data
//   forward_*          forwarding-unit claims and values
//   ex_mem_*           load detection for the instruction in MEM
//   mem_stall          freeze request from MEM
//   ex_take_branch     squash request from EX
//   id_ex_*            registered ID/EX packet
//   if_id_stall        combinational hold request toward fetch/decode
//   load_use_stall_cycles  saturating bubble counter
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);

  logic              if_id_valid;
  logic [XLEN-1:0]   if_id_pc;
  logic [4:0]        if_id_rs1;
  logic [4:0]        if_id_rs2;
  logic [4:0]        if_id_dest_reg_idx;
  logic              if_id_rd_mem;
  logic              if_id_wr_mem;
  logic [CTRL_W-1:0] if_id_ctrl;
  logic [XLEN-1:0]   rf_rega;
  logic [XLEN-1:0]   rf_regb;
  logic              forward_rs1;
  logic              forward_rs2;
  logic [XLEN-1:0]   forward_rega_out;
  logic [XLEN-1:0]   forward_regb_out;
  logic [4:0]        ex_mem_dest_reg_idx;
  logic              ex_mem_rd_mem;
  logic              mem_stall;
  logic              ex_take_branch;

  logic              id_ex_valid;
  logic [XLEN-1:0]   id_ex_pc;
  logic [XLEN-1:0]   id_ex_rega;
  logic [XLEN-1:0]   id_ex_regb;
  logic [4:0]        id_ex_dest_reg_idx;
  logic              id_ex_rd_mem;
  logic              id_ex_wr_mem;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              if_id_stall;
  logic [31:0]       load_use_stall_cycles;

  modport master (
    output if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_dest_reg_idx,
           if_id_rd_mem, if_id_wr_mem, if_id_ctrl, rf_rega, rf_regb,
           forward_rs1, forward_rs2, forward_rega_out, forward_regb_out,
           ex_mem_dest_reg_idx, ex_mem_rd_mem, mem_stall, ex_take_branch,
    input  id_ex_valid, id_ex_pc, id_ex_rega, id_ex_regb, id_ex_dest_reg_idx,
           id_ex_rd_mem, id_ex_wr_mem, id_ex_ctrl, if_id_stall,
           load_use_stall_cycles
  );

  modport slave (
    input  if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_dest_reg_idx,
           if_id_rd_mem, if_id_wr_mem, if_id_ctrl, rf_rega, rf_regb,
           forward_rs1, forward_rs2, forward_rega_out, forward_regb_out,
           ex_mem_dest_reg_idx, ex_mem_rd_mem, mem_stall, ex_take_branch,
    output id_ex_valid, id_ex_pc, id_ex_rega, id_ex_regb, id_ex_dest_reg_idx,
           id_ex_rd_mem, id_ex_wr_mem, id_ex_ctrl, if_id_stall,
           load_use_stall_cycles
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare for the instruction in decode
// against loads currently in EX (the ID/EX register) and in MEM.
// Ports:
//   if_id_valid_i        decode slot holds a real instruction
//   rs1_i, rs2_i         decode source indices
//   ex_valid_i           ID/EX holds a real instruction
//   ex_rd_mem_i, ex_dest_i   load flag / destination of the instruction in EX
//   mem_rd_mem_i, mem_dest_i load flag / destination of the instruction in MEM
//   hazard_o             decode must wait for the load data
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic       if_id_valid_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_rd_mem_i,
  input  logic [4:0] ex_dest_i,
  input  logic       mem_rd_mem_i,
  input  logic [4:0] mem_dest_i,
  output logic       hazard_o
);

  logic ex_hit;
  logic mem_hit;

  // x0 is never a real producer, so a load targeting it never blocks.
  assign ex_hit  = ex_valid_i & ex_rd_mem_i & (ex_dest_i != 5'd0) &
                   ((ex_dest_i == rs1_i) | (ex_dest_i == rs2_i));
  assign mem_hit = mem_rd_mem_i & (mem_dest_i != 5'd0) &
                   ((mem_dest_i == rs1_i) | (mem_dest_i == rs2_i));

  assign hazard_o = if_id_valid_i & (ex_hit | mem_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. Resolves operands from the register
// file or the forwarding network, inserts bubbles on load-use hazards while
// holding IF/ID, squashes on an EX redirect and freezes on a memory stall.
// Ports:
//   clock   pipeline clock, rising edge
//   reset   synchronous, active-high
//   bus     id_ex_stage_if.slave (all pipeline inputs and ID/EX outputs)
// Update priority per edge: reset > mem_stall hold > branch squash >
// load-use bubble > normal capture.
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int XLEN   = XLEN_DEF
) (
  input  logic          clock,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic [XLEN-1:0] id_rega;
  logic [XLEN-1:0] id_regb;
  logic            load_use_hazard;

  id_ex_packet_t   pkt_d, pkt_q;
  logic [31:0]     load_use_cnt_d, load_use_cnt_q;

  assign id_rega = bus.forward_rs1 ? bus.forward_rega_out : bus.rf_rega;
  assign id_regb = bus.forward_rs2 ? bus.forward_regb_out : bus.rf_regb;

  load_use_detect u_load_use_detect (
    .if_id_valid_i (bus.if_id_valid),
    .rs1_i         (bus.if_id_rs1),
    .rs2_i         (bus.if_id_rs2),
    .ex_valid_i    (pkt_q.valid),
    .ex_rd_mem_i   (pkt_q.rd_mem),
    .ex_dest_i     (pkt_q.dest),
    .mem_rd_mem_i  (bus.ex_mem_rd_mem),
    .mem_dest_i    (bus.ex_mem_dest_reg_idx),
    .hazard_o      (load_use_hazard)
  );

  always_comb begin
    pkt_d          = pkt_q;
    load_use_cnt_d = load_use_cnt_q;
    // Under mem_stall everything holds; EX keeps presenting ex_take_branch
    // until the stall releases, so ignoring it here loses nothing.
    if (!bus.mem_stall) begin
      if (bus.ex_take_branch) begin
        pkt_d = ID_EX_NOP;
      end else if (load_use_hazard) begin
        pkt_d          = ID_EX_NOP;
        load_use_cnt_d = sat_inc32(load_use_cnt_q);
      end else begin
        pkt_d.valid  = bus.if_id_valid;
        pkt_d.pc     = bus.if_id_pc;
        pkt_d.rega   = id_rega;
        pkt_d.regb   = id_regb;
        pkt_d.ctrl   = bus.if_id_ctrl[CTRL_W-1:0];
        // An empty slot must not look like a load or a producer downstream.
        pkt_d.dest   = bus.if_id_valid ? bus.if_id_dest_reg_idx : 5'd0;
        pkt_d.rd_mem = bus.if_id_valid & bus.if_id_rd_mem;
        pkt_d.wr_mem = bus.if_id_valid & bus.if_id_wr_mem;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_q          <= ID_EX_NOP;
      load_use_cnt_q <= '0;
    end else begin
      pkt_q          <= pkt_d;
      load_use_cnt_q <= load_use_cnt_d;
    end
  end

  // A squash makes the younger instruction irrelevant, so the hazard must not
  // hold fetch in that cycle.
  assign bus.if_id_stall = bus.mem_stall | (load_use_hazard & ~bus.ex_take_branch);

  assign bus.id_ex_valid           = pkt_q.valid;
  assign bus.id_ex_pc              = pkt_q.pc;
  assign bus.id_ex_rega            = pkt_q.rega;
  assign bus.id_ex_regb            = pkt_q.regb;
  assign bus.id_ex_dest_reg_idx    = pkt_q.dest;
  assign bus.id_ex_rd_mem          = pkt_q.rd_mem;
  assign bus.id_ex_wr_mem          = pkt_q.wr_mem;
  assign bus.id_ex_ctrl            = pkt_q.ctrl;
  assign bus.load_use_stall_cycles = load_use_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;

  id_ex_stage_if #(.XLEN(32), .CTRL_W(16)) bus();

  id_ex_stage #(.CTRL_W(16), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.if_id_valid         = 1'b0;
    bus.if_id_pc            = '0;
    bus.if_id_rs1           = '0;
    bus.if_id_rs2           = '0;
    bus.if_id_dest_reg_idx  = '0;
    bus.if_id_rd_mem        = 1'b0;
    bus.if_id_wr_mem        = 1'b0;
    bus.if_id_ctrl          = '0;
    bus.rf_rega             = '0;
    bus.rf_regb             = '0;
    bus.forward_rs1         = 1'b0;
    bus.forward_rs2         = 1'b0;
    bus.forward_rega_out    = '0;
    bus.forward_regb_out    = '0;
    bus.ex_mem_dest_reg_idx = '0;
    bus.ex_mem_rd_mem       = 1'b0;
    bus.mem_stall           = 1'b0;
    bus.ex_take_branch      = 1'b0;
  endtask

  task automatic drive_random();
    bus.if_id_valid         = 1'($urandom);
    bus.if_id_pc            = $urandom;
    bus.if_id_rs1           = 5'($urandom);
    bus.if_id_rs2           = 5'($urandom);
    bus.if_id_dest_reg_idx  = 5'($urandom);
    bus.if_id_rd_mem        = 1'($urandom);
    bus.if_id_wr_mem        = 1'($urandom);
    bus.if_id_ctrl          = 16'($urandom);
    bus.rf_rega             = $urandom;
    bus.rf_regb             = $urandom;
    bus.forward_rs1         = 1'($urandom);
    bus.forward_rs2         = 1'($urandom);
    bus.forward_rega_out    = $urandom;
    bus.forward_regb_out    = $urandom;
    bus.ex_mem_dest_reg_idx = 5'($urandom);
    bus.ex_mem_rd_mem       = 1'($urandom);
    bus.mem_stall           = 1'($urandom);
    bus.ex_take_branch      = 1'($urandom);
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] dest,
                             input logic rd_mem, input logic wr_mem);
    bus.if_id_valid        = 1'b1;
    bus.if_id_pc           = pc;
    bus.if_id_rs1          = rs1;
    bus.if_id_rs2          = rs2;
    bus.if_id_dest_reg_idx = dest;
    bus.if_id_rd_mem       = rd_mem;
    bus.if_id_wr_mem       = wr_mem;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_random();
    tick();
    drive_random();
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", bus.id_ex_valid); else pass_cnt++;
    check_cnt++; if (bus.id_ex_pc !== 32'h0) $display("FAIL reset_pc got=%0h exp=0", bus.id_ex_pc); else pass_cnt++;
    check_cnt++; if (bus.id_ex_rega !== 32'h0) $display("FAIL reset_rega got=%0h exp=0", bus.id_ex_rega); else pass_cnt++;
    check_cnt++; if (bus.id_ex_regb !== 32'h0) $display("FAIL reset_regb got=%0h exp=0", bus.id_ex_regb); else pass_cnt++;
    check_cnt++; if (bus.id_ex_dest_reg_idx !== 5'd0) $display("FAIL reset_dest got=%0h exp=0", bus.id_ex_dest_reg_idx); else pass_cnt++;
    check_cnt++; if (bus.id_ex_rd_mem !== 1'b0) $display("FAIL reset_rd_mem got=%0h exp=0", bus.id_ex_rd_mem); else pass_cnt++;
    check_cnt++; if (bus.id_ex_wr_mem !== 1'b0) $display("FAIL reset_wr_mem got=%0h exp=0", bus.id_ex_wr_mem); else pass_cnt++;
    check_cnt++; if (bus.id_ex_ctrl !== 16'h0) $display("FAIL reset_ctrl got=%0h exp=0", bus.id_ex_ctrl); else pass_cnt++;
    check_cnt++; if (bus.load_use_stall_cycles !== 32'h0) $display("FAIL reset_cnt got=%0h exp=0", bus.load_use_stall_cycles); else pass_cnt++;
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_forward();
    drive_instr(32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    bus.if_id_ctrl       = 16'h00A5;
    bus.rf_rega          = 32'h0000_1234;
    bus.rf_regb          = 32'h0000_5678;
    bus.forward_rs1      = 1'b1;
    bus.forward_rega_out = 32'hDEAD_BEEF;
    bus.forward_rs2      = 1'b0;
    bus.forward_regb_out = 32'hCAFE_F00D;
    tick();
    check_cnt++; if (bus.id_ex_rega !== 32'hDEAD_BEEF) $display("FAIL fwd_a_sel got=%0h exp=deadbeef", bus.id_ex_rega); else pass_cnt++;
    check_cnt++; if (bus.id_ex_regb !== 32'h0000_5678) $display("FAIL fwd_b_rf got=%0h exp=5678", bus.id_ex_regb); else pass_cnt++;
    check_cnt++; if (bus.id_ex_valid !== 1'b1) $display("FAIL fwd_valid got=%0h exp=1", bus.id_ex_valid); else pass_cnt++;
    check_cnt++; if (bus.id_ex_pc !== 32'h100) $display("FAIL fwd_pc got=%0h exp=100", bus.id_ex_pc); else pass_cnt++;
    check_cnt++; if (bus.id_ex_ctrl !== 16'h00A5) $display("FAIL fwd_ctrl got=%0h exp=a5", bus.id_ex_ctrl); else pass_cnt++;
    check_cnt++; if (bus.id_ex_dest_reg_idx !== 5'd3) $display("FAIL fwd_dest got=%0d exp=3", bus.id_ex_dest_reg_idx); else pass_cnt++;

    bus.forward_rs1 = 1'b0;
    bus.forward_rs2 = 1'b1;
    tick();
    check_cnt++; if (bus.id_ex_rega !== 32'h0000_1234) $display("FAIL fwd_a_rf got=%0h exp=1234", bus.id_ex_rega); else pass_cnt++;
    check_cnt++; if (bus.id_ex_regb !== 32'hCAFE_F00D) $display("FAIL fwd_b_sel got=%0h exp=cafef00d", bus.id_ex_regb); else pass_cnt++;

    // Empty slot: load/store flags and destination are scrubbed.
    drive_instr(32'h104, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    bus.if_id_valid = 1'b0;
    bus.forward_rs2 = 1'b0;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0) $display("FAIL inv_valid got=%0h exp=0", bus.id_ex_valid); else pass_cnt++;
    check_cnt++; if (bus.id_ex_dest_reg_idx !== 5'd0) $display("FAIL inv_dest got=%0d exp=0", bus.id_ex_dest_reg_idx); else pass_cnt++;
    check_cnt++; if (bus.id_ex_rd_mem !== 1'b0) $display("FAIL inv_rd_mem got=%0h exp=0", bus.id_ex_rd_mem); else pass_cnt++;
    check_cnt++; if (bus.id_ex_wr_mem !== 1'b0) $display("FAIL inv_wr_mem got=%0h exp=0", bus.id_ex_wr_mem); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_load_use();
    // lw x5 ; add x6, x5, x1
    drive_instr(32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL lu_load_nostall got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_rd_mem !== 1'b1 || bus.id_ex_dest_reg_idx !== 5'd5) $display("FAIL lu_load_ex rd=%0h dest=%0d exp rd=1 dest=5", bus.id_ex_rd_mem, bus.id_ex_dest_reg_idx); else pass_cnt++;
    drive_instr(32'h404, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    bus.rf_rega = 32'h55;
    bus.rf_regb = 32'h66;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL lu_stall_ex got=%0h exp=1", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.load_use_stall_cycles !== 32'd1) $display("FAIL lu_bubble1 valid=%0h cnt=%0d exp valid=0 cnt=1", bus.id_ex_valid, bus.load_use_stall_cycles); else pass_cnt++;
    bus.ex_mem_dest_reg_idx = 5'd5;
    bus.ex_mem_rd_mem       = 1'b1;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL lu_stall_mem got=%0h exp=1", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.load_use_stall_cycles !== 32'd2) $display("FAIL lu_bubble2 valid=%0h cnt=%0d exp valid=0 cnt=2", bus.id_ex_valid, bus.load_use_stall_cycles); else pass_cnt++;
    bus.ex_mem_dest_reg_idx = 5'd0;
    bus.ex_mem_rd_mem       = 1'b0;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL lu_release got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b1 || bus.id_ex_pc !== 32'h404 || bus.id_ex_rega !== 32'h55 || bus.id_ex_dest_reg_idx !== 5'd6) $display("FAIL lu_capture valid=%0h pc=%0h rega=%0h dest=%0d exp 1/404/55/6", bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_rega, bus.id_ex_dest_reg_idx); else pass_cnt++;
    check_cnt++; if (bus.load_use_stall_cycles !== 32'd2) $display("FAIL lu_cnt_after got=%0d exp=2", bus.load_use_stall_cycles); else pass_cnt++;

    // Dependent instruction one slot behind the load: a single bubble.
    drive_instr(32'h500, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    tick();
    drive_instr(32'h504, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0);
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL slot1_indep got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    tick();
    bus.ex_mem_dest_reg_idx = 5'd7;
    bus.ex_mem_rd_mem       = 1'b1;
    drive_instr(32'h508, 5'd7, 5'd3, 5'd9, 1'b0, 1'b0);
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL slot1_stall got=%0h exp=1", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.load_use_stall_cycles !== 32'd3) $display("FAIL slot1_bubble valid=%0h cnt=%0d exp valid=0 cnt=3", bus.id_ex_valid, bus.load_use_stall_cycles); else pass_cnt++;
    bus.ex_mem_dest_reg_idx = 5'd0;
    bus.ex_mem_rd_mem       = 1'b0;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b1 || bus.id_ex_pc !== 32'h508 || bus.load_use_stall_cycles !== 32'd3) $display("FAIL slot1_capture valid=%0h pc=%0h cnt=%0d exp 1/508/3", bus.id_ex_valid, bus.id_ex_pc, bus.load_use_stall_cycles); else pass_cnt++;

    // Load into x0 never blocks.
    drive_instr(32'h600, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    drive_instr(32'h604, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL x0_nostall got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b1 || bus.id_ex_pc !== 32'h604 || bus.load_use_stall_cycles !== 32'd3) $display("FAIL x0_capture valid=%0h pc=%0h cnt=%0d exp 1/604/3", bus.id_ex_valid, bus.id_ex_pc, bus.load_use_stall_cycles); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_flush_vs_hazard();
    drive_instr(32'h700, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    tick();
    drive_instr(32'h704, 5'd9, 5'd2, 5'd10, 1'b0, 1'b0);
    bus.ex_take_branch = 1'b1;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL flush_nostall got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.id_ex_pc !== 32'h0 || bus.id_ex_rd_mem !== 1'b0) $display("FAIL flush_bubble valid=%0h pc=%0h rd=%0h exp 0/0/0", bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_rd_mem); else pass_cnt++;
    check_cnt++; if (bus.load_use_stall_cycles !== 32'd3) $display("FAIL flush_cnt got=%0d exp=3", bus.load_use_stall_cycles); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_mem_stall();
    drive_instr(32'h200, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
    bus.rf_rega    = 32'hAAAA;
    bus.if_id_ctrl = 16'h0F0F;
    tick();
    check_cnt++; if (bus.id_ex_pc !== 32'h200 || bus.id_ex_rd_mem !== 1'b1) $display("FAIL ms_setup pc=%0h rd=%0h exp 200/1", bus.id_ex_pc, bus.id_ex_rd_mem); else pass_cnt++;
    // New IF/ID content depends on the held load, and EX asks for a squash.
    bus.mem_stall      = 1'b1;
    bus.ex_take_branch = 1'b1;
    drive_instr(32'h300, 5'd10, 5'd3, 5'd11, 1'b0, 1'b0);
    bus.rf_rega    = 32'hBBBB;
    bus.if_id_ctrl = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL ms_stall[%0d] got=%0h exp=1", i, bus.if_id_stall); else pass_cnt++;
      tick();
      check_cnt++; if (bus.id_ex_valid !== 1'b1 || bus.id_ex_pc !== 32'h200 || bus.id_ex_rega !== 32'hAAAA || bus.id_ex_ctrl !== 16'h0F0F || bus.load_use_stall_cycles !== 32'd3) $display("FAIL ms_hold[%0d] valid=%0h pc=%0h rega=%0h ctrl=%0h cnt=%0d exp 1/200/aaaa/f0f/3", i, bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_rega, bus.id_ex_ctrl, bus.load_use_stall_cycles); else pass_cnt++;
    end
    bus.mem_stall      = 1'b0;
    bus.ex_take_branch = 1'b0;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL ms_post_hazard got=%0h exp=1", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.load_use_stall_cycles !== 32'd4) $display("FAIL ms_post_bubble valid=%0h cnt=%0d exp 0/4", bus.id_ex_valid, bus.load_use_stall_cycles); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_reset_mid_stall();
    drive_instr(32'h800, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
    tick();
    drive_instr(32'h804, 5'd12, 5'd0, 5'd13, 1'b0, 1'b0);
    tick();
    bus.ex_mem_dest_reg_idx = 5'd12;
    bus.ex_mem_rd_mem       = 1'b1;
    reset = 1'b1;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b1) $display("FAIL rms_stall_comb got=%0h exp=1", bus.if_id_stall); else pass_cnt++;
    tick();
    check_cnt++; if (bus.id_ex_valid !== 1'b0 || bus.load_use_stall_cycles !== 32'd0) $display("FAIL rms_clear valid=%0h cnt=%0d exp 0/0", bus.id_ex_valid, bus.load_use_stall_cycles); else pass_cnt++;
    reset = 1'b0;
    bus.ex_mem_dest_reg_idx = 5'd0;
    bus.ex_mem_rd_mem       = 1'b0;
    #1;
    check_cnt++; if (bus.if_id_stall !== 1'b0) $display("FAIL rms_release got=%0h exp=0", bus.if_id_stall); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_counter_saturation();
    drive_instr(32'h900, 5'd12, 5'd0, 5'd13, 1'b0, 1'b0);
    bus.ex_mem_dest_reg_idx = 5'd12;
    bus.ex_mem_rd_mem       = 1'b1;
    force dut.load_use_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.load_use_cnt_q;
    #1;
    check_cnt++; if (bus.load_use_stall_cycles !== 32'hFFFF_FFFD) $display("FAIL sat_preload got=%0h exp=fffffffd", bus.load_use_stall_cycles); else pass_cnt++;
    tick();
    check_cnt++; if (bus.load_use_stall_cycles !== 32'hFFFF_FFFE) $display("FAIL sat_step1 got=%0h exp=fffffffe", bus.load_use_stall_cycles); else pass_cnt++;
    tick();
    check_cnt++; if (bus.load_use_stall_cycles !== 32'hFFFF_FFFF) $display("FAIL sat_step2 got=%0h exp=ffffffff", bus.load_use_stall_cycles); else pass_cnt++;
    tick();
    check_cnt++; if (bus.load_use_stall_cycles !== 32'hFFFF_FFFF) $display("FAIL sat_hold got=%0h exp=ffffffff", bus.load_use_stall_cycles); else pass_cnt++;
    drive_idle();
    tick();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_flush_vs_hazard();
    test_mem_stall();
    test_reset_mid_stall();
    test_counter_saturation();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
